// File: rtl/rx_uart_pkg.sv
// Shared types and constants for the rx_uart receiver and the soc read mux.
// Status bit positions here match the layout of the status byte.
package rx_uart_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StWaitIdle
  } rx_state_e;

  localparam int unsigned StatusNotEmptyBit = 0;
  localparam int unsigned StatusFullBit     = 1;
  localparam int unsigned StatusOverrunBit  = 2;
  localparam int unsigned StatusFrameErrBit = 3;

  localparam logic [7:0] MinDivisor = 8'd4;

  // Below four clocks per bit the half-bit sample point no longer clears the synchroniser delay.
  function automatic logic [7:0] clamp_divisor(input logic [7:0] value);
    return (value < MinDivisor) ? MinDivisor : value;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with extra-MSB pointers; head is presented combinationally.
// Reads as zero when empty so it can be ORed straight into a read mux.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic [WIDTH-1:0] r_mem [DEPTH];

  logic w_full;
  logic w_empty;
  logic w_do_push;
  logic w_do_pop;

  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);

  // A pop on a full FIFO frees the slot the simultaneous push writes into.
  assign w_do_pop  = i_pop & ~w_empty;
  assign w_do_push = i_push & (~w_full | i_pop);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wptr[AW-1:0]] <= i_wdata;
  end

  assign o_rdata = w_empty ? '0 : r_mem[r_rptr[AW-1:0]];
  assign o_full  = w_full;
  assign o_empty = w_empty;

endmodule

// File: rtl/rx_uart.sv
// Memory-mapped 8N1 UART receiver: synchroniser, programmable bit period, frame FSM,
// receive FIFO and sticky error flags.
module rx_uart
  import rx_uart_pkg::*;
#(
  parameter logic [7:0]  DEFAULT_DIVISOR = 8'd104,
  parameter int unsigned FIFO_DEPTH      = 8
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_rx_line,
  input  logic [7:0] i_config_data,
  input  logic       i_config_enable,
  input  logic       i_pop_enable,
  input  logic       i_status_clear,
  output logic [7:0] o_read_data,
  output logic [7:0] o_status
);

  rx_state_e r_state;
  rx_state_e w_state_next;

  logic       r_sync1;
  logic       r_sync2;
  logic       r_sync3;
  logic [7:0] r_divisor;
  logic [7:0] r_bit_period;
  logic [7:0] r_cnt;
  logic [2:0] r_bit_idx;
  logic [7:0] r_shift;
  logic       r_overrun;
  logic       r_frame_err;

  logic       w_fall;
  logic [7:0] w_half_tgt;
  logic [7:0] w_full_tgt;
  logic       w_cnt_clr;
  logic       w_load_period;
  logic       w_shift_en;
  logic       w_push;
  logic       w_frame_set;
  logic       w_overrun_set;
  logic       w_fifo_full;
  logic       w_fifo_empty;

  // r_sync3 is the previous synchronised value, used only for edge detection.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_sync3 <= 1'b1;
    end else begin
      r_sync1 <= i_rx_line;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
    end
  end

  assign w_fall = r_sync3 & ~r_sync2;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_divisor <= DEFAULT_DIVISOR;
    end else if (i_config_enable) begin
      r_divisor <= clamp_divisor(i_config_data);
    end
  end

  // Start sample lands one clock early to absorb the synchroniser and edge-detect delay.
  assign w_half_tgt = {1'b0, r_bit_period[7:1]} - 8'd1;
  assign w_full_tgt = r_bit_period - 8'd1;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_cnt_clr     = 1'b0;
    w_load_period = 1'b0;
    w_shift_en    = 1'b0;
    w_push        = 1'b0;
    w_frame_set   = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_fall) begin
          w_cnt_clr     = 1'b1;
          w_load_period = 1'b1;
          w_state_next  = StStart;
        end
      end
      StStart: begin
        if (r_cnt == w_half_tgt) begin
          w_cnt_clr    = 1'b1;
          w_state_next = r_sync2 ? StIdle : StData;
        end
      end
      StData: begin
        if (r_cnt == w_full_tgt) begin
          w_cnt_clr  = 1'b1;
          w_shift_en = 1'b1;
          if (r_bit_idx == 3'd7) w_state_next = StStop;
        end
      end
      StStop: begin
        if (r_cnt == w_full_tgt) begin
          w_cnt_clr = 1'b1;
          if (r_sync2) begin
            w_push       = 1'b1;
            w_state_next = StIdle;
          end else begin
            w_frame_set  = 1'b1;
            w_state_next = StWaitIdle;
          end
        end
      end
      StWaitIdle: begin
        if (r_sync2) w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_bit_period <= DEFAULT_DIVISOR;
      r_cnt        <= '0;
      r_bit_idx    <= '0;
      r_shift      <= '0;
    end else begin
      r_cnt <= w_cnt_clr ? 8'd0 : r_cnt + 8'd1;
      if (w_load_period) begin
        r_bit_period <= r_divisor;
        r_bit_idx    <= '0;
      end
      if (w_shift_en) begin
        r_shift   <= {r_sync2, r_shift[7:1]};
        r_bit_idx <= r_bit_idx + 3'd1;
      end
    end
  end

  // A push that meets a full FIFO is only lost when no pop frees a slot that cycle.
  assign w_overrun_set = w_push & w_fifo_full & ~i_pop_enable;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_overrun   <= w_overrun_set | (r_overrun & ~i_status_clear);
      r_frame_err <= w_frame_set | (r_frame_err & ~i_status_clear);
    end
  end

  sync_fifo #(
    .WIDTH(8),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (w_push),
    .i_wdata (r_shift),
    .i_pop   (i_pop_enable),
    .o_rdata (o_read_data),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  assign o_status = {4'b0000, r_frame_err, r_overrun, w_fifo_full, ~w_fifo_empty};

endmodule

// File: tb/tb_rx_uart.sv
// Self-checking bench for rx_uart: directed vectors, corner-case sequences and
// random frames checked against a queue-based model.
module tb_rx_uart;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_line = 1'b1;
  logic [7:0] cfg_data = 8'h00;
  logic       cfg_en = 1'b0;
  logic       pop = 1'b0;
  logic       clr = 1'b0;
  logic [7:0] rd;
  logic [7:0] st;

  int checks = 0;
  int errors = 0;

  byte unsigned model_q[$];
  bit           model_ovr = 1'b0;
  bit           model_ferr = 1'b0;

  typedef struct {
    logic [7:0] cfg;
    int         bit_clks;
    logic [7:0] data;
    bit         stop;
    bit         do_pop;
    bit         do_clr;
    logic [7:0] exp_status;
    logic [7:0] exp_rdata;
  } vec_t;

  vec_t vecs[6];

  rx_uart #(
    .DEFAULT_DIVISOR(8'd104),
    .FIFO_DEPTH(8)
  ) dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_rx_line       (rx_line),
    .i_config_data   (cfg_data),
    .i_config_enable (cfg_en),
    .i_pop_enable    (pop),
    .i_status_clear  (clr),
    .o_read_data     (rd),
    .o_status        (st)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h", name, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_div(input logic [7:0] d);
    @(negedge clk);
    cfg_data = d;
    cfg_en   = 1'b1;
    @(negedge clk);
    cfg_en   = 1'b0;
  endtask

  task automatic do_pop();
    @(negedge clk);
    pop = 1'b1;
    @(negedge clk);
    pop = 1'b0;
  endtask

  task automatic do_clear();
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  // Drives one frame; pop_at >= 0 raises pop for one clock at that negedge index of the frame.
  task automatic send(input logic [7:0] data, input int div, input bit stop, input int pop_at);
    logic [9:0] bits;
    int n;
    bits = {stop, data, 1'b0};
    n = 0;
    @(negedge clk);
    for (int b = 0; b < 10; b++) begin
      for (int c = 0; c < div; c++) begin
        rx_line = bits[b];
        pop = (pop_at >= 0) && (n == pop_at);
        n++;
        @(negedge clk);
      end
    end
    rx_line = 1'b1;
    pop = 1'b0;
  endtask

  task automatic glitch(input int len);
    @(negedge clk);
    rx_line = 1'b0;
    tick(len);
    rx_line = 1'b1;
  endtask

  task automatic model_frame(input logic [7:0] data, input bit stop);
    if (!stop) model_ferr = 1'b1;
    else if (model_q.size() < 8) model_q.push_back(data);
    else model_ovr = 1'b1;
  endtask

  task automatic check_model(input string name);
    logic [7:0] exp_st;
    logic [7:0] exp_rd;
    exp_st = {4'b0000, model_ferr, model_ovr, model_q.size() == 8, model_q.size() != 0};
    exp_rd = (model_q.size() != 0) ? model_q[0] : 8'h00;
    chk({name, " status"}, st, exp_st);
    chk({name, " read_data"}, rd, exp_rd);
  endtask

  initial begin
    int lat;
    int cfg;
    int div;
    logic [7:0] data;
    bit stop;

    vecs[0] = '{8'd16, 16, 8'hA5, 1'b1, 1'b1, 1'b0, 8'h01, 8'hA5};
    vecs[1] = '{8'd16, 16, 8'h3C, 1'b0, 1'b0, 1'b1, 8'h08, 8'h00};
    vecs[2] = '{8'h02,  4, 8'h5A, 1'b1, 1'b0, 1'b0, 8'h01, 8'h5A};
    vecs[3] = '{8'd8,   8, 8'hFF, 1'b1, 1'b1, 1'b0, 8'h01, 8'h5A};
    vecs[4] = '{8'd5,   5, 8'h00, 1'b1, 1'b1, 1'b0, 8'h01, 8'hFF};
    vecs[5] = '{8'd20, 20, 8'h81, 1'b0, 1'b1, 1'b1, 8'h09, 8'h00};

    tick(3);
    chk("reset status", st, 8'h00);
    chk("reset read_data", rd, 8'h00);
    rst_n = 1'b1;
    tick(2);
    chk("post-reset status", st, 8'h00);

    // Default divisor after reset.
    send(8'h96, 104, 1'b1, -1);
    tick(4);
    chk("default div status", st, 8'h01);
    chk("default div data", rd, 8'h96);
    do_pop();
    chk("default div pop", st, 8'h00);

    // Start-edge to visible-byte latency.
    set_div(8'd16);
    lat = 0;
    fork
      send(8'hA5, 16, 1'b1, -1);
      begin
        @(negedge clk);
        while (!st[0] && lat < 400) begin
          @(negedge clk);
          lat++;
        end
      end
    join
    checks++;
    if (lat < 150 || lat > 160) begin
      errors++;
      $display("FAIL latency: got %0d clocks expected 150..160", lat);
    end
    tick(2);
    chk("A5 status", st, 8'h01);
    chk("A5 data", rd, 8'hA5);
    do_pop();
    chk("A5 pop status", st, 8'h00);

    // Glitch rejection and the shortest accepted start bit.
    glitch(1);
    tick(200);
    chk("1-clk glitch", st, 8'h00);
    glitch(6);
    tick(200);
    chk("6-clk glitch", st, 8'h00);
    glitch(9);
    tick(200);
    chk("9-clk start status", st, 8'h01);
    chk("9-clk start data", rd, 8'hFF);
    do_pop();

    // Break: one framing error, no bytes, no retrigger.
    @(negedge clk);
    rx_line = 1'b0;
    tick(40 * 16);
    rx_line = 1'b1;
    tick(40);
    chk("break status", st, 8'h08);
    chk("break read_data", rd, 8'h00);
    do_clear();
    chk("break cleared", st, 8'h00);

    // Overfill by one.
    set_div(8'd8);
    for (int i = 0; i < 9; i++) begin
      send(8'(i), 8, 1'b1, -1);
      tick(4);
    end
    chk("overfill status", st, 8'h07);
    for (int i = 0; i < 8; i++) begin
      chk("overfill order", rd, 8'(i));
      do_pop();
    end
    chk("drained status", st, 8'h04);
    do_clear();
    chk("drained cleared", st, 8'h00);

    // Push from the stop sample coincides with a pop on a full FIFO.
    for (int i = 0; i < 8; i++) begin
      send(8'h10 + 8'(i), 8, 1'b1, -1);
      tick(4);
    end
    chk("full status", st, 8'h03);
    send(8'h18, 8, 1'b1, 4 + 2 + 9 * 8);
    tick(4);
    chk("full push+pop status", st, 8'h03);
    chk("full push+pop head", rd, 8'h11);
    for (int i = 1; i < 9; i++) begin
      chk("full push+pop order", rd, 8'h10 + 8'(i));
      do_pop();
    end
    chk("full push+pop drained", st, 8'h00);

    // Reset in the middle of a frame with a byte already queued.
    send(8'h77, 8, 1'b1, -1);
    tick(4);
    @(negedge clk);
    rx_line = 1'b0;
    tick(20);
    rst_n = 1'b0;
    tick(5);
    rx_line = 1'b1;
    tick(2);
    rst_n = 1'b1;
    tick(300);
    chk("mid-frame reset status", st, 8'h00);
    chk("mid-frame reset data", rd, 8'h00);

    for (int v = 0; v < 6; v++) begin
      set_div(vecs[v].cfg);
      send(vecs[v].data, vecs[v].bit_clks, vecs[v].stop, -1);
      tick(4);
      chk($sformatf("vec%0d status", v), st, vecs[v].exp_status);
      chk($sformatf("vec%0d read_data", v), rd, vecs[v].exp_rdata);
      if (vecs[v].do_pop) do_pop();
      if (vecs[v].do_clr) do_clear();
    end

    for (int r = 0; r < 40; r++) begin
      cfg  = $urandom_range(0, 10);
      div  = (cfg < 4) ? 4 : cfg;
      data = 8'($urandom);
      stop = ($urandom_range(0, 9) != 0);
      set_div(8'(cfg));
      send(data, div, stop, -1);
      tick(4);
      model_frame(data, stop);
      check_model($sformatf("rand%0d", r));
      repeat ($urandom_range(0, 2)) begin
        do_pop();
        if (model_q.size() != 0) void'(model_q.pop_front());
      end
      if ($urandom_range(0, 5) == 0) begin
        do_clear();
        model_ovr  = 1'b0;
        model_ferr = 1'b0;
      end
      check_model($sformatf("rand%0d after", r));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
